// File: rtl/signed_divider_pkg.sv
// Shared arithmetic types and helpers for the signed divider datapath.
package arith_pkg;

    localparam int DEFAULT_W = 4;

    // Widest operand abs_ext accepts; callers sign-extend into it and truncate the result.
    localparam int ABS_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    // Zero-padded magnitude one bit wider than x, so the most negative value survives.
    function automatic logic [ABS_W:0] abs_ext(input logic signed [ABS_W-1:0] x);
        logic [ABS_W:0] wide;
        wide = {x[ABS_W-1], x};
        return x[ABS_W-1] ? (~wide + (ABS_W+1)'(1)) : wide;
    endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the signed divider.
interface signed_divider_if
    import arith_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic              start;
    logic [2*W-1:0]    dividend;
    logic [W-1:0]      divisor;
    logic [W-1:0]      quotient;
    logic [W-1:0]      remainder;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              dbz;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, ovf, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, ovf, dbz
    );
endinterface

// File: rtl/signed_divider_div_step.sv
// One restoring division iteration on magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative.
module div_step #(
    parameter int W = 4
) (
    input  logic [2*W-1:0] rem_in,
    input  logic           shift_in,
    input  logic [W-1:0]   dmag,
    output logic [2*W-1:0] rem_out,
    output logic           q_bit
);
    localparam int DW = 2 * W;

    logic [DW:0] trial;

    // Trial subtraction at 2W+1 bits; the top bit is the borrow.
    always_comb begin
        trial   = {rem_in, shift_in} - (DW+1)'(dmag);
        q_bit   = ~trial[DW];
        rem_out = q_bit ? trial[DW-1:0] : {rem_in[DW-2:0], shift_in};
    end
endmodule

// File: rtl/signed_divider.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor, restoring on
// magnitudes one bit per clock, C-style sign correction and saturation at the end.
module signed_divider
    import arith_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic             clk,
    input  logic             rst,
    signed_divider_if.slave  bus
);
    localparam int DW    = 2 * W;
    localparam int CNT_W = $clog2(DW) + 1;
    localparam logic [DW-1:0] HALF = DW'(1) << (W - 1);

    state_t          state;
    state_t          state_next;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   quo;
    logic [W-1:0]    dmag;
    logic            sd;
    logic            sv;
    logic            zdiv;

    logic [W-1:0]    q_reg;
    logic [W-1:0]    r_reg;
    logic            done_reg;
    logic            ovf_reg;
    logic            dbz_reg;

    logic [DW-1:0]   dd_mag;
    logic [W-1:0]    dv_mag;
    logic [DW-1:0]   step_rem;
    logic            step_bit;

    logic            q_neg;
    logic            q_big;
    logic            ovf_fix;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;

    // Magnitudes of the incoming operands; -2^(2W-1) still fits 2W unsigned bits.
    assign dd_mag = DW'(abs_ext(ABS_W'(signed'(bus.dividend))));
    assign dv_mag = W'(abs_ext(ABS_W'(signed'(bus.divisor))));

    div_step #(.W(W)) u_step (
        .rem_in   (rem),
        .shift_in (quo[DW-1]),
        .dmag     (dmag),
        .rem_out  (step_rem),
        .q_bit    (step_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: fixed 2W steps, then one correction cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == CNT_W'(DW - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sign correction, overflow saturation and divide-by-zero override.
    always_comb begin
        q_neg   = sd ^ sv;
        q_big   = q_neg ? (quo > HALF) : (quo >= HALF);
        ovf_fix = 1'b0;
        q_fix   = '0;
        r_fix   = '0;
        if (!zdiv) begin
            ovf_fix = q_big;
            r_fix   = sd ? -rem[W-1:0] : rem[W-1:0];
            if (q_big) q_fix = q_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else       q_fix = q_neg ? -quo[W-1:0] : quo[W-1:0];
        end
    end

    // Operand latch, iteration registers and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dmag     <= '0;
            sd       <= 1'b0;
            sv       <= 1'b0;
            zdiv     <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            done_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            dbz_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        quo  <= dd_mag;
                        dmag <= dv_mag;
                        sd   <= bus.dividend[DW-1];
                        sv   <= bus.divisor[W-1];
                        zdiv <= (bus.divisor == '0);
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    quo <= {quo[DW-2:0], step_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    q_reg    <= q_fix;
                    r_reg    <= r_fix;
                    ovf_reg  <= ovf_fix;
                    dbz_reg  <= zdiv;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == RUN) || (state == FIX);
    assign bus.done      = done_reg;
    assign bus.quotient  = q_reg;
    assign bus.remainder = r_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.dbz       = dbz_reg;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: integer-arithmetic reference with a
// latency countdown, per-cycle comparison, directed and random stimulus.
module tb_signed_divider;
    localparam int W  = 4;
    localparam int DW = 2 * W;
    localparam int LAT = 2 * W + 1;

    logic clk;
    logic rst;

    signed_divider_if #(.W(W)) bus ();

    signed_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pending literal checks, evaluated by the compare process.
    string pn[$];
    int    pg[$];
    int    pw[$];

    // Reference model state.
    bit           m_started = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_done = 0;
    logic         m_ovf = 0;
    logic         m_dbz = 0;
    int           p_q, p_r, p_o, p_z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C semantics: truncate toward zero, remainder follows dividend, saturate on overflow.
    function automatic void model(input int dd, input int dv,
                                  output int q, output int r, output int o, output int z);
        int lo;
        int hi;
        lo = -(1 << (W - 1));
        hi = (1 << (W - 1)) - 1;
        q = 0; r = 0; o = 0; z = 0;
        if (dv == 0) begin
            z = 1;
        end else begin
            q = dd / dv;
            r = dd % dv;
            if (q > hi) begin q = hi; o = 1; end
            else if (q < lo) begin q = lo; o = 1; end
        end
    endfunction

    task automatic expect_eq(input string n, input int g, input int w);
        pn.push_back(n);
        pg.push_back(g);
        pw.push_back(w);
    endtask

    // Cycle-level reference: an accepted start produces its result LAT edges later.
    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_cnt = 0; m_q = '0; m_r = '0; m_done = 0; m_ovf = 0; m_dbz = 0;
        end else begin
            m_done = 0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_q = W'(p_q); m_r = W'(p_r);
                    m_ovf = p_o[0]; m_dbz = p_z[0]; m_done = 1;
                end
            end else if (bus.start) begin
                model(int'($signed(bus.dividend)), int'($signed(bus.divisor)), p_q, p_r, p_o, p_z);
                m_cnt = LAT;
            end
        end
    end

    // Compare DUT against the model every cycle, then drain literal checks.
    always @(negedge clk) begin
        logic [2*W+3:0] got;
        logic [2*W+3:0] want;
        if (m_started) begin
            got  = {bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder};
            want = {(m_cnt != 0), m_done, m_ovf, m_dbz, m_q, m_r};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cycle t=%0t got busy/done/ovf/dbz/q/r=%b want %b", $time, got, want);
            end
        end
        while (pn.size() > 0) begin
            string n;
            int g;
            int w;
            n = pn.pop_front();
            g = pg.pop_front();
            w = pw.pop_front();
            checks++;
            if (g != w) begin
                errors++;
                $display("FAIL %s got %0d want %0d", n, g, w);
            end
        end
    end

    // Issue one operation from idle and check its result against literals.
    task automatic run_op(input int dd, input int dv, input int eq, input int er,
                          input int eo, input int ez);
        int lat;
        bus.dividend = DW'(dd);
        bus.divisor  = W'(dv);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        expect_eq("latency", lat, LAT);
        expect_eq("quotient", int'($signed(bus.quotient)), eq);
        expect_eq("remainder", int'($signed(bus.remainder)), er);
        expect_eq("ovf", int'(bus.ovf), eo);
        expect_eq("dbz", int'(bus.dbz), ez);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int q, r, o, z;
        int busy_cnt;

        // Literal pins for the reference model.
        model(42, 6, q, r, o, z);    expect_eq("model_42_6_q", q, 7);
        model(-45, -7, q, r, o, z);  expect_eq("model_n45_n7_r", r, -3);
        model(45, -7, q, r, o, z);   expect_eq("model_45_n7_q", q, -6);
        model(-128, 1, q, r, o, z);  expect_eq("model_n128_1_q", q, -8);
        expect_eq("model_n128_1_ovf", o, 1);
        model(37, 0, q, r, o, z);    expect_eq("model_37_0_dbz", z, 1);

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_outputs",
                  int'({bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic case with busy-width measurement.
        bus.dividend = DW'(42); bus.divisor = W'(6); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && bus.busy === 1'b1; i++) begin
            busy_cnt++;
            @(posedge clk); #1;
        end
        expect_eq("busy_cycles", busy_cnt, LAT);
        expect_eq("q_42_6", int'($signed(bus.quotient)), 7);
        expect_eq("done_42_6", int'(bus.done), 1);

        @(posedge clk); #1;
        // Back-to-back: each run_op starts in the previous done cycle.
        run_op(-45, 7, -6, -3, 0, 0);
        run_op(45, -7, -6, 3, 0, 0);
        run_op(-45, -7, 6, -3, 0, 0);
        run_op(100, 3, 7, 1, 1, 0);
        run_op(-128, -1, 7, 0, 1, 0);
        run_op(-128, 1, -8, 0, 1, 0);
        run_op(37, 0, 0, 0, 0, 1);
        run_op(-8, 2, -4, 0, 0, 0);

        // start re-asserted mid-RUN with other operands is ignored.
        bus.dividend = DW'(42); bus.divisor = W'(6); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.dividend = DW'(-45); bus.divisor = W'(7); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        begin
            int k;
            k = 0;
            while (bus.done !== 1'b1 && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            expect_eq("midrun_done_seen", int'(bus.done), 1);
        end
        expect_eq("midrun_q", int'($signed(bus.quotient)), 7);
        expect_eq("midrun_r", int'($signed(bus.remainder)), 0);

        // Reset at step 3 discards the operation.
        @(posedge clk); #1;
        run_op(-45, 7, -6, -3, 0, 0);
        bus.dividend = DW'(42); bus.divisor = W'(6); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        expect_eq("midrun_reset_outputs",
                  int'({bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder}), 0);
        rst = 1'b0;

        // Round trip of the multiplier product 1110 x 1110 = 4.
        run_op(4, -2, -2, 0, 0, 0);

        // Random traffic: starts while busy, zero divisors, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.dividend = DW'($urandom);
            bus.divisor  = W'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end

        rst = 1'b0;
        bus.start = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
